// File: rtl/trace_stack_ctrl.sv
// Assignment-trail stack for the DPLL core: records decision/forced entries
// and streams them back on backtrack until the latest decision is removed.
module trace_stack_ctrl #(
    parameter int DEPTH = 128,
    parameter int VAR_W = 9,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic             push_type,
    input  logic             push_val,
    input  logic [VAR_W-1:0] push_var,
    input  logic             bt_start,
    output logic             bt_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_type,
    output logic             out_val,
    output logic [VAR_W-1:0] out_var,
    output logic             out_last,
    output logic             out_unsat,
    output logic             unsat_empty,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = VAR_W + 2;

    typedef enum logic {IDLE, BT} state_t;

    state_t           state;
    logic [ENT_W-1:0] stack [DEPTH];
    logic [ENT_W-1:0] top_ent;
    logic [ENT_W-1:0] next_ent;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             push_fire;
    logic             pop_fire;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign bt_busy    = (state == BT);
    assign push_ready = (state == IDLE) && !full && !bt_start && !clear;
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = out_valid && out_ready;

    assign top_idx  = IDX_W'(count - CNT_W'(1));
    assign next_idx = IDX_W'(count - CNT_W'(2));
    assign wr_idx   = IDX_W'(count);
    assign top_ent  = stack[top_idx];
    assign next_ent = stack[next_idx];

    // Entry layout: {type, val, var}; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            stack[wr_idx] <= {push_type, push_val, push_var};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            level       <= '0;
            out_valid   <= 1'b0;
            out_type    <= 1'b0;
            out_val     <= 1'b0;
            out_var     <= '0;
            out_last    <= 1'b0;
            out_unsat   <= 1'b0;
            unsat_empty <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unsat_empty <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                count     <= '0;
                level     <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_unsat <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (push_valid && full) begin
                            overflow <= 1'b1;
                        end
                        if (bt_start) begin
                            if (!empty) begin
                                state     <= BT;
                                out_valid <= 1'b1;
                                out_type  <= top_ent[ENT_W-1];
                                out_val   <= top_ent[ENT_W-2];
                                out_var   <= top_ent[VAR_W-1:0];
                                out_last  <= !top_ent[ENT_W-1]
                                             || (count == CNT_W'(1));
                                out_unsat <= top_ent[ENT_W-1]
                                             && (count == CNT_W'(1));
                            end else begin
                                unsat_empty <= 1'b1;
                            end
                        end else if (push_fire) begin
                            count <= count + CNT_W'(1);
                            if (!push_type) begin
                                level <= level + CNT_W'(1);
                            end
                        end
                    end
                    BT: begin
                        if (pop_fire) begin
                            count <= count - CNT_W'(1);
                            if (!out_type) begin
                                level <= level - CNT_W'(1);
                            end
                            // Chain straight into the next entry to keep 1/cycle.
                            if (!out_last) begin
                                out_type  <= next_ent[ENT_W-1];
                                out_val   <= next_ent[ENT_W-2];
                                out_var   <= next_ent[VAR_W-1:0];
                                out_last  <= !next_ent[ENT_W-1]
                                             || (count == CNT_W'(2));
                                out_unsat <= next_ent[ENT_W-1]
                                             && (count == CNT_W'(2));
                            end else begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                out_unsat <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/trace_stack_ctrl.md
# trace_stack_ctrl

Parametrised assignment-trail stack for the DPLL solver core. It records every variable assignment as a decision or forced entry and tracks the current decision level. On a conflict, it streams popped entries back to the assignment unit one per cycle over a valid/ready handshake, until the most recent decision entry has been removed. It sits between the decision/BCP controller and the variable-assignment memory.

## Interface
Parameters
- DEPTH, 128, maximum stored entries
- VAR_W, 9, variable index width
- CNT_W, $clog2(DEPTH+1), width of count and level

Ports
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- clear  in  1  synchronous flush, highest priority after reset
- push_valid  in  1  push request
- push_ready  out  1  push accepted when push_valid && push_ready
- push_type  in  1  0 = decision, 1 = forced (implied)
- push_val  in  1  assigned truth value
- push_var  in  VAR_W  variable index
- bt_start  in  1  single-cycle backtrack request
- bt_busy  out  1  backtrack in progress
- out_valid  out  1  popped entry present
- out_ready  in  1  consumer accepts popped entry
- out_type, out_val  out  1 each  popped entry fields
- out_var  out  VAR_W  popped variable index
- out_last  out  1  final entry of this backtrack
- out_unsat  out  1  valid with out_last: stack drained without a decision
- unsat_empty  out  1  one-cycle pulse: bt_start issued on empty stack
- count  out  CNT_W  entries stored
- level  out  CNT_W  decision entries stored
- full, empty  out  1 each  count==DEPTH / count==0
- overflow  out  1  sticky: push_valid seen while IDLE and full

## Operation
- Storage: DEPTH x (VAR_W+2) register array; top entry at index count-1.
- States: IDLE, BT.
- push_ready = IDLE && !full && !bt_start && !clear.
- Accepted push: write stack[count]; count+1; level+1 if push_type==0.
- IDLE, bt_start, count>0: load the out registers from stack[count-1] and go to BT. out_valid=1. out_last=1 if the entry is a decision or count==1. out_unsat=1 if count==1 and the entry is forced.
- IDLE, bt_start, count==0: unsat_empty pulses next cycle. State stays IDLE. Nothing is output.
- BT handshake (out_valid && out_ready): count-1; level-1 if out_type==0.
  - If out_last=0: reload the out registers from stack[count-2] in the same cycle. out_valid stays 1.
  - If out_last=1: out_valid=0 and go to IDLE.
- out_valid && !out_ready: all out_* fields hold stable.
- bt_start while BT: ignored. Pushes are blocked in BT.
- push_valid while IDLE && full: not accepted; overflow set.
- clear: count=0, level=0, state IDLE, out_valid=0, overflow=0. Array contents are don't-care.
- bt_busy = (state==BT).

## Timing
- Reset (async assert, any cycle including mid-backtrack): state IDLE; count, level, out_*, out_valid, unsat_empty, overflow all 0. Consequently full=0, empty=1, push_ready=1 once reset deasserts.
- Push accepted at edge N: count/level/full updated after edge N. An entry is backtrackable from cycle N+1.
- bt_start at edge N: out_valid=1 after edge N.
- Sustained out_ready gives a throughput of 1 entry per cycle. A k-entry backtrack completes in k cycles; push_ready is high in the cycle after the last handshake.
- unsat_empty is high exactly 1 cycle.
- Simultaneous push_valid and bt_start in IDLE: backtrack wins, push not accepted.
- Simultaneous clear with anything: clear wins.

## Test plan
- Reset/push: push D(v3,T), F(v7,F), F(v9,T) -> count=3, level=1, empty=0. Async reset mid-stream -> all outputs 0, empty=1.
- Backtrack to decision: stack D1,F2,D4,F5,F6, bt_start, out_ready=1 -> out_var 6,5,4 on consecutive cycles, last on 4, out_unsat=0. Then count=2, level=1.
- Backpressure: same stack, out_ready toggling 1,0,0,1,1 -> each entry held stable while stalled. No loss or duplication; 3 entries emitted over 5 cycles.
- UNSAT drain: stack F1,F2 -> out_var 2,1, last+out_unsat on var 1, count=0. bt_start on empty -> unsat_empty pulses 1 cycle, out_valid stays 0.
- Full/overflow with DEPTH=4: 4 pushes -> full=1, push_ready=0. A 5th push_valid sets overflow; count stays 4. clear -> overflow=0, count=0.
- Contention: push_valid and bt_start in the same cycle -> push dropped, backtrack proceeds. bt_start during BT -> ignored.
